// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared states, opcodes, field encodings and control word layout
package legv8_ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_e;
  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_ORR, C_ADDS, C_SUBS, C_ADDI, C_SUBI,
    C_B, C_BCOND, C_BR, C_LDUR, C_STUR, C_ILL
  } cls_e;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [1:0] DT_ALU = 2'b00;
  localparam logic [1:0] DT_REGB = 2'b01;
  localparam logic [1:0] DT_PC4 = 2'b10;
  localparam logic [1:0] DT_MEM = 2'b11;
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC = 2'b01;
  localparam logic [1:0] PC_ADD = 2'b10;
  localparam logic [1:0] PC_LOAD = 2'b11;
  localparam logic [1:0] MEM_RAM = 2'b01;
  localparam logic [1:0] SIZE_64 = 2'b11;
  localparam logic [4:0] COND_EQ = 5'h00;
  localparam logic [4:0] COND_NE = 5'h01;
  localparam logic [4:0] COND_HS = 5'h02;
  localparam logic [4:0] COND_LO = 5'h03;
  localparam logic [4:0] COND_MI = 5'h04;
  localparam logic [4:0] COND_PL = 5'h05;
  localparam logic [4:0] COND_GE = 5'h0A;
  localparam logic [4:0] COND_LT = 5'h0B;
  localparam logic [4:0] COND_AL = 5'h0E;
  typedef struct packed {
    logic [4:0] fs;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       w_reg;
    logic       c0;
    logic [1:0] mem_cs;
    logic       b_sel;
    logic       mem_write_en;
    logic       ir_load;
    logic       status_load;
    logic [1:0] size;
    logic       add_tri_sel;
    logic [1:0] data_tri_sel;
    logic       pc_sel;
    logic [1:0] pc_fs;
  } cw_t;
  function automatic logic [35:0] pack_cw(input cw_t c);
    return c;
  endfunction
  function automatic logic cond_true(input logic [4:0] cond, input logic [3:0] st);
    logic v, c, n, z;
    {v, c, n, z} = st;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_HS: return c;
      COND_LO: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/instr_decode.sv
// instr_decode: classifies IR, extracts register fields and forms the branch/immediate constant
module instr_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output cls_e        cls,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic [4:0]  rd,
  output logic [4:0]  rt,
  output logic        has_k,
  output logic [63:0] k_val
);
  assign rn = ir[9:5];
  assign rm = ir[20:16];
  assign rd = ir[4:0];
  assign rt = ir[4:0];
  assign cls = ir[31:21] == OP_ADD   ? C_ADD   :
               ir[31:21] == OP_SUB   ? C_SUB   :
               ir[31:21] == OP_AND   ? C_AND   :
               ir[31:21] == OP_ORR   ? C_ORR   :
               ir[31:21] == OP_ADDS  ? C_ADDS  :
               ir[31:21] == OP_SUBS  ? C_SUBS  :
               ir[31:21] == OP_BR    ? C_BR    :
               ir[31:21] == OP_LDUR  ? C_LDUR  :
               ir[31:21] == OP_STUR  ? C_STUR  :
               ir[31:22] == OP_ADDI  ? C_ADDI  :
               ir[31:22] == OP_SUBI  ? C_SUBI  :
               ir[31:26] == OP_B     ? C_B     :
               ir[31:24] == OP_BCOND ? C_BCOND : C_ILL;
  // branch offsets drop 4 because PC already advanced during fetch
  always_comb begin
    has_k = 1'b1;
    k_val = '0;
    case (cls)
      C_ADDI, C_SUBI: k_val = {52'b0, ir[21:10]};
      C_LDUR, C_STUR: k_val = {{55{ir[20]}}, ir[20:12]};
      C_B:            k_val = {{36{ir[25]}}, ir[25:0], 2'b00} - 64'd4;
      C_BCOND:        k_val = {{43{ir[23]}}, ir[23:5], 2'b00} - 64'd4;
      default:        has_k = 1'b0;
    endcase
  end
endmodule

// File: rtl/legv8_control_unit.sv
// legv8_control_unit: multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the LEGv8 datapath
module legv8_control_unit
  import legv8_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  status,
  input  logic        mem_ready,
  output logic [35:0] controlWord,
  output logic [63:0] k,
  output logic [2:0]  state_out,
  output logic        halted,
  output logic        fault
);
  state_e      state_q, state_d;
  logic [63:0] k_q, k_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;
  cw_t         cw;
  cls_e        cls;
  logic [4:0]  rn, rm, rd, rt;
  logic        has_k, timeout, sub;
  logic [63:0] dec_k;
  instr_decode u_dec (
    .ir(IR), .cls(cls), .rn(rn), .rm(rm), .rd(rd), .rt(rt), .has_k(has_k), .k_val(dec_k)
  );
  assign timeout = WAIT_LIMIT > 0 && cnt_q == 32'(WAIT_LIMIT) && !mem_ready;
  assign sub = cls inside {C_SUB, C_SUBS, C_SUBI};
  // next state, control word, constant, fault and wait-counter updates
  always_comb begin
    cw = '0;
    state_d = state_q;
    k_d = k_q;
    fault_d = fault_q;
    case (state_q)
      FETCH: begin
        cw.add_tri_sel = 1'b1;
        cw.mem_cs = MEM_RAM;
        cw.data_tri_sel = DT_MEM;
        cw.ir_load = mem_ready;
        cw.pc_fs = mem_ready ? PC_INC : PC_HOLD;
        state_d = mem_ready ? DECODE : timeout ? HALT : FETCH;
        fault_d = fault_q | timeout;
      end
      DECODE: begin
        k_d = has_k ? dec_k : k_q;
        state_d = cls == C_ILL ? HALT : cls inside {C_LDUR, C_STUR} ? MEM : EXEC;
        fault_d = fault_q | (cls == C_ILL);
      end
      EXEC: begin
        state_d = FETCH;
        case (cls)
          C_ADD, C_SUB, C_AND, C_ORR, C_ADDS, C_SUBS, C_ADDI, C_SUBI: begin
            cw.fs = cls == C_AND ? FS_AND : cls == C_ORR ? FS_OR : sub ? FS_SUB : FS_ADD;
            cw.c0 = sub;
            cw.sa = rn;
            cw.sb = rm;
            cw.da = rd;
            cw.w_reg = 1'b1;
            cw.b_sel = cls inside {C_ADDI, C_SUBI};
            cw.status_load = cls inside {C_ADDS, C_SUBS};
            cw.data_tri_sel = DT_ALU;
          end
          C_B: begin
            cw.pc_sel = 1'b1;
            cw.pc_fs = PC_ADD;
          end
          C_BCOND: begin
            cw.pc_sel = 1'b1;
            cw.pc_fs = cond_true(rd, status) ? PC_ADD : PC_HOLD;
          end
          C_BR: begin
            cw.sa = rn;
            cw.pc_fs = PC_LOAD;
          end
          default: ;
        endcase
      end
      MEM: begin
        cw.fs = FS_ADD;
        cw.sa = rn;
        cw.b_sel = 1'b1;
        cw.mem_cs = MEM_RAM;
        cw.size = SIZE_64;
        cw.data_tri_sel = cls == C_STUR ? DT_REGB : DT_MEM;
        cw.sb = cls == C_STUR ? rt : 5'd0;
        cw.da = cls == C_STUR ? 5'd0 : rt;
        cw.mem_write_en = cls == C_STUR;
        cw.w_reg = cls == C_LDUR && mem_ready;
        state_d = mem_ready ? FETCH : timeout ? HALT : MEM;
        fault_d = fault_q | timeout;
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
    cnt_d = state_d != state_q ? '0 :
            (state_q inside {FETCH, MEM} && !mem_ready) ? cnt_q + 32'd1 : cnt_q;
  end
  // state registers, cleared asynchronously when reset goes low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      k_q <= '0;
      fault_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      fault_q <= fault_d;
      cnt_q <= cnt_d;
    end
  end
  assign controlWord = reset ? pack_cw(cw) : 36'd0;
  assign k = k_q;
  assign state_out = state_q;
  assign halted = state_q == HALT;
  assign fault = fault_q;
endmodule

// File: tb/tb_legv8_control_unit.sv
// tb_legv8_control_unit: directed checks of the control FSM against hand-computed control words
module tb_legv8_control_unit;
  import legv8_ctrl_pkg::*;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic [3:0]  status;
  logic        mem_ready;
  logic [35:0] controlWord;
  logic [63:0] k;
  logic [2:0]  state_out;
  logic        halted;
  logic        fault;
  int total = 0;
  int bad = 0;
  legv8_control_unit #(.WAIT_LIMIT(4)) dut (
    .clock(clock), .reset(reset), .IR(IR), .status(status), .mem_ready(mem_ready),
    .controlWord(controlWord), .k(k), .state_out(state_out), .halted(halted), .fault(fault)
  );
  always #5 clock = ~clock;
  function automatic logic [35:0] mk(
    input logic [4:0] fs, input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
    input logic w, input logic c0, input logic [1:0] mcs, input logic bs, input logic mwe,
    input logic irl, input logic sl, input logic [1:0] sz, input logic ats,
    input logic [1:0] dts, input logic pcs, input logic [1:0] pcfs);
    return {fs, sa, sb, da, w, c0, mcs, bs, mwe, irl, sl, sz, ats, dts, pcs, pcfs};
  endfunction
  task automatic tick();
    @(posedge clock);
    #2;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  initial begin
    logic [35:0] cw_fetch, cw_fetch_rdy, cw_ld_wait, cw_ld_done, cw_st;
    cw_fetch     = mk(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b01, 0, 0, 0, 0, 2'b00, 1, 2'b11, 0, 2'b00);
    cw_fetch_rdy = mk(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b01, 0, 0, 1, 0, 2'b00, 1, 2'b11, 0, 2'b01);
    cw_ld_wait   = mk(5'b01000, 5'd1, 5'd0, 5'd2, 0, 0, 2'b01, 1, 0, 0, 0, 2'b11, 0, 2'b11, 0, 2'b00);
    cw_ld_done   = mk(5'b01000, 5'd1, 5'd0, 5'd2, 1, 0, 2'b01, 1, 0, 0, 0, 2'b11, 0, 2'b11, 0, 2'b00);
    cw_st        = mk(5'b01000, 5'd1, 5'd2, 5'd0, 0, 0, 2'b01, 1, 1, 0, 0, 2'b11, 0, 2'b01, 0, 2'b00);
    reset = 1'b0;
    IR = '0;
    status = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_cw", controlWord, 36'd0);
    chk("rst_state", state_out, 3'd0);
    chk("rst_k", k, 64'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    reset = 1'b1;
    #1 chk("fetch_idle_cw", controlWord, cw_fetch);
    IR = 32'h8B020023;
    mem_ready = 1'b1;
    #1 chk("fetch_ready_cw", controlWord, cw_fetch_rdy);
    tick();
    chk("add_decode_state", state_out, 3'd1);
    chk("add_decode_cw", controlWord, 36'd0);
    tick();
    chk("add_exec_state", state_out, 3'd2);
    chk("add_exec_cw", controlWord, mk(5'b01000, 5'd1, 5'd2, 5'd3, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00));
    tick();
    chk("add_return_fetch", state_out, 3'd0);
    IR = 32'h91001401;
    tick();
    tick();
    chk("addi_k", k, 64'd5);
    chk("addi_exec_cw", controlWord, mk(5'b01000, 5'd0, 5'd0, 5'd1, 1, 0, 2'b00, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00));
    tick();
    IR = 32'hF8408022;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("ldur_k", k, 64'd8);
    chk("ldur_mem_state", state_out, 3'd3);
    chk("ldur_wait1_cw", controlWord, cw_ld_wait);
    tick();
    tick();
    chk("ldur_wait3_cw", controlWord, cw_ld_wait);
    tick();
    chk("ldur_mem4_state", state_out, 3'd3);
    mem_ready = 1'b1;
    #1 chk("ldur_done_cw", controlWord, cw_ld_done);
    tick();
    chk("ldur_return_fetch", state_out, 3'd0);
    IR = 32'hF8010022;
    tick();
    mem_ready = 1'b0;
    tick();
    chk("stur_k", k, 64'd16);
    chk("stur_mem_cw", controlWord, cw_st);
    reset = 1'b0;
    #1;
    chk("midmem_rst_cw", controlWord, 36'd0);
    chk("midmem_rst_state", state_out, 3'd0);
    chk("midmem_rst_k", k, 64'd0);
    tick();
    chk("rst_held_cw", controlWord, 36'd0);
    reset = 1'b1;
    #1 chk("post_rst_fetch_cw", controlWord, cw_fetch);
    for (int i = 0; i < 4; i++) tick();
    chk("timeout_still_fetch", state_out, 3'd0);
    chk("timeout_no_fault_yet", fault, 1'b0);
    tick();
    chk("timeout_halt_state", state_out, 3'd4);
    chk("timeout_halted", halted, 1'b1);
    chk("timeout_fault", fault, 1'b1);
    chk("timeout_halt_cw", controlWord, 36'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1 chk("fault_cleared", fault, 1'b0);
    IR = 32'h54000040;
    status = 4'b0001;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("beq_k", k, 64'd4);
    chk("beq_taken_cw", controlWord, mk(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b10));
    tick();
    status = 4'b0000;
    tick();
    tick();
    chk("beq_not_taken_cw", controlWord, mk(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00));
    tick();
    IR = 32'h5400004A;
    status = 4'b1000;
    tick();
    tick();
    chk("bge_not_taken_cw", controlWord, mk(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00));
    status = 4'b1010;
    #1 chk("bge_taken_cw", controlWord, mk(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b10));
    tick();
    IR = 32'h00000000;
    tick();
    tick();
    chk("illegal_halt_state", state_out, 3'd4);
    chk("illegal_halted", halted, 1'b1);
    chk("illegal_fault", fault, 1'b1);
    chk("illegal_halt_cw", controlWord, 36'd0);
    tick();
    chk("halt_sticky", state_out, 3'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
